// File: rtl/tia_hsync_decode.sv
// Horizontal timing decoder for the 6-bit horizontal LFSR counter.
// On each counter phase-2 strobe the current counter code is decoded into
// set/reset latches (HSYNC, HBLANK, colour burst) and single-cycle pulses
// (centre, counter reset, lock-up error). The block also owns the WSYNC
// CPU stall and the HMOVE extended-blank latch.
module tia_hsync_decode #(
    parameter logic [5:0] SHS_CODE  = 6'b111100, // count 4: set HSYNC
    parameter logic [5:0] RHS_CODE  = 6'b110111, // count 8: reset HSYNC, set burst
    parameter logic [5:0] RCB_CODE  = 6'b001111, // count 12: reset burst
    parameter logic [5:0] RHB_CODE  = 6'b011100, // count 16: normal HBLANK end
    parameter logic [5:0] LRHB_CODE = 6'b010111, // count 18: late HBLANK end
    parameter logic [5:0] CNT_CODE  = 6'b101100, // count 36: line centre
    parameter logic [5:0] END_CODE  = 6'b010100, // count 56: end of line
    parameter logic [5:0] LOCK_CODE = 6'b111111  // illegal lock-up state
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hphi2_en,
    input  logic [5:0] lfsr,
    input  logic       hmove_strobe,
    input  logic       wsync_strobe,
    output logic       hsync,
    output logic       hblank,
    output logic       cburst,
    output logic       center,
    output logic       lfsr_reset,
    output logic       lock_err,
    output logic       rdy,
    output logic       hmove_pending
);

    logic hsync_d,  hsync_q;
    logic hblank_d, hblank_q;
    logic cburst_d, cburst_q;
    logic center_d, center_q;
    logic lreset_d, lreset_q;
    logic lock_d,   lock_q;
    logic rdy_d,    rdy_q;
    logic hmove_d,  hmove_q;

    // Next-state decode: latches hold unless a decode or strobe acts; pulses default low.
    always_comb begin
        hsync_d  = hsync_q;
        hblank_d = hblank_q;
        cburst_d = cburst_q;
        center_d = 1'b0;
        lreset_d = 1'b0;
        lock_d   = 1'b0;
        rdy_d    = rdy_q;
        hmove_d  = hmove_q;

        if (hphi2_en) begin
            case (lfsr)
                SHS_CODE: hsync_d = 1'b1;
                RHS_CODE: begin
                    hsync_d  = 1'b0;
                    cburst_d = 1'b1;
                end
                RCB_CODE: cburst_d = 1'b0;
                // With HMOVE pending, blanking is extended to the late code.
                RHB_CODE: begin
                    if (!hmove_q) hblank_d = 1'b0;
                end
                LRHB_CODE: begin
                    if (hmove_q) begin
                        hblank_d = 1'b0;
                        hmove_d  = 1'b0;
                    end
                end
                CNT_CODE: center_d = 1'b1;
                END_CODE: begin
                    hblank_d = 1'b1;
                    lreset_d = 1'b1;
                    rdy_d    = 1'b1;
                end
                // Lock-up recovery: force the counter back and blank the line.
                LOCK_CODE: begin
                    lock_d   = 1'b1;
                    lreset_d = 1'b1;
                    hblank_d = 1'b1;
                    hsync_d  = 1'b0;
                    cburst_d = 1'b0;
                    rdy_d    = 1'b1;
                end
                default: ;
            endcase
        end

        // CPU strobes are applied last so they win over a same-cycle clear/release.
        if (hmove_strobe) hmove_d = 1'b1;
        if (wsync_strobe) rdy_d   = 1'b0;
    end

    // State registers with asynchronous active-low reset to the blanked, ready state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q  <= 1'b0;
            hblank_q <= 1'b1;
            cburst_q <= 1'b0;
            center_q <= 1'b0;
            lreset_q <= 1'b0;
            lock_q   <= 1'b0;
            rdy_q    <= 1'b1;
            hmove_q  <= 1'b0;
        end else begin
            hsync_q  <= hsync_d;
            hblank_q <= hblank_d;
            cburst_q <= cburst_d;
            center_q <= center_d;
            lreset_q <= lreset_d;
            lock_q   <= lock_d;
            rdy_q    <= rdy_d;
            hmove_q  <= hmove_d;
        end
    end

    assign hsync         = hsync_q;
    assign hblank        = hblank_q;
    assign cburst        = cburst_q;
    assign center        = center_q;
    assign lfsr_reset    = lreset_q;
    assign lock_err      = lock_q;
    assign rdy           = rdy_q;
    assign hmove_pending = hmove_q;

endmodule

// File: tb/tb_tia_hsync_decode.sv
// Bench for tia_hsync_decode: vector table, full-line scenarios and a
// randomized run, all compared against a behavioural model of the decode rules.
module tb_tia_hsync_decode;

    localparam logic [5:0] SHS  = 6'b111100;
    localparam logic [5:0] RHS  = 6'b110111;
    localparam logic [5:0] RCB  = 6'b001111;
    localparam logic [5:0] RHB  = 6'b011100;
    localparam logic [5:0] LRHB = 6'b010111;
    localparam logic [5:0] CNT  = 6'b101100;
    localparam logic [5:0] ENDC = 6'b010100;
    localparam logic [5:0] LOCK = 6'b111111;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       hphi2_en;
    logic [5:0] lfsr;
    logic       hmove_strobe;
    logic       wsync_strobe;
    logic       hsync, hblank, cburst, center, lfsr_reset, lock_err, rdy, hmove_pending;

    tia_hsync_decode dut (
        .clk(clk), .reset_n(reset_n), .hphi2_en(hphi2_en), .lfsr(lfsr),
        .hmove_strobe(hmove_strobe), .wsync_strobe(wsync_strobe),
        .hsync(hsync), .hblank(hblank), .cburst(cburst), .center(center),
        .lfsr_reset(lfsr_reset), .lock_err(lock_err), .rdy(rdy),
        .hmove_pending(hmove_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] dut_vec();
        return {hsync, hblank, cburst, center, lfsr_reset, lock_err, rdy, hmove_pending};
    endfunction

    // ---------------- behavioural reference model ----------------
    logic m_hs, m_hb, m_cb, m_ce, m_lr, m_le, m_rdy, m_hm;

    task automatic model_reset();
        m_hs = 0; m_hb = 1; m_cb = 0; m_ce = 0; m_lr = 0; m_le = 0; m_rdy = 1; m_hm = 0;
    endtask

    task automatic model_update(input logic h, input logic [5:0] l, input logic hm, input logic ws);
        logic nhm, nrdy;
        nhm = m_hm; nrdy = m_rdy;
        m_ce = 0; m_lr = 0; m_le = 0;
        if (h) begin
            if (l == SHS) m_hs = 1;
            else if (l == RHS) begin m_hs = 0; m_cb = 1; end
            else if (l == RCB) m_cb = 0;
            else if (l == RHB) begin if (!m_hm) m_hb = 0; end
            else if (l == LRHB) begin if (m_hm) begin m_hb = 0; nhm = 0; end end
            else if (l == CNT) m_ce = 1;
            else if (l == ENDC) begin m_hb = 1; m_lr = 1; nrdy = 1; end
            else if (l == LOCK) begin m_le = 1; m_lr = 1; m_hb = 1; m_hs = 0; m_cb = 0; nrdy = 1; end
        end
        if (hm) nhm = 1;
        if (ws) nrdy = 0;
        m_hm = nhm; m_rdy = nrdy;
    endtask

    // One clock: drive inputs, clock, sample 1 time unit later, compare with the model.
    task automatic step(input logic h, input logic [5:0] l, input logic hm, input logic ws);
        hphi2_en = h; lfsr = l; hmove_strobe = hm; wsync_strobe = ws;
        @(posedge clk); #1;
        model_update(h, l, hm, ws);
        check("model", {24'd0, dut_vec()},
              {24'd0, m_hs, m_hb, m_cb, m_ce, m_lr, m_le, m_rdy, m_hm});
    endtask

    // ---------------- legal code sequence ----------------
    logic [5:0] seq [57];

    // ---------------- line-level observations ----------------
    int hs_clks, cb_clks, hs_rise, cb_rise, hb_fall, ce_cnt, ce_at, lr_cnt, lr_at;
    logic rdy_after_ws, rdy_at56, hm_at18, hm_after_strobe;

    // Run one line: counts 0..56, phase-2 strobe on the first of every 4 clocks.
    // stop_at < 57 ends the line early after the second clock of that count.
    task automatic run_line(input int hm_at, input int ws_at, input int stop_at);
        logic prev_hb;
        hs_clks = 0; cb_clks = 0; hs_rise = -1; cb_rise = -1; hb_fall = -1;
        ce_cnt = 0; ce_at = -1; lr_cnt = 0; lr_at = -1;
        rdy_after_ws = 1'bx; rdy_at56 = 1'bx; hm_at18 = 1'bx; hm_after_strobe = 1'bx;
        for (int c = 0; c < 57; c++) begin
            for (int k = 0; k < 4; k++) begin
                prev_hb = hblank;
                step(k == 0, seq[c], (c == hm_at) && (k == 0), (c == ws_at) && (k == 0));
                if (hsync) begin hs_clks++; if (hs_rise < 0) hs_rise = c; end
                if (cburst) begin cb_clks++; if (cb_rise < 0) cb_rise = c; end
                if (prev_hb && !hblank && hb_fall < 0) hb_fall = c;
                if (center) begin ce_cnt++; ce_at = c; end
                if (lfsr_reset) begin lr_cnt++; lr_at = c; end
                if (k == 0 && c == ws_at) rdy_after_ws = rdy;
                if (k == 0 && c == 56) rdy_at56 = rdy;
                if (k == 0 && c == 18) hm_at18 = hmove_pending;
                if (k == 0 && c == hm_at) hm_after_strobe = hmove_pending;
                if (c == stop_at && k == 1) return;
            end
        end
    endtask

    typedef struct {
        logic       h;
        logic [5:0] l;
        logic       hm;
        logic       ws;
        logic [7:0] exp; // {hsync,hblank,cburst,center,lfsr_reset,lock_err,rdy,hmove_pending}
    } vec_t;

    vec_t tbl [18];

    task automatic do_reset();
        reset_n = 0; hphi2_en = 0; lfsr = 0; hmove_strobe = 0; wsync_strobe = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
    endtask

    initial begin
        logic [5:0] s;
        tbl[0]  = '{1'b1, SHS,   1'b0, 1'b0, 8'b1100_0010};
        tbl[1]  = '{1'b0, RHS,   1'b0, 1'b0, 8'b1100_0010};
        tbl[2]  = '{1'b1, RHS,   1'b0, 1'b0, 8'b0110_0010};
        tbl[3]  = '{1'b1, RCB,   1'b0, 1'b0, 8'b0100_0010};
        tbl[4]  = '{1'b0, 6'd0,  1'b1, 1'b0, 8'b0100_0011};
        tbl[5]  = '{1'b1, RHB,   1'b0, 1'b0, 8'b0100_0011};
        tbl[6]  = '{1'b1, LRHB,  1'b0, 1'b0, 8'b0000_0010};
        tbl[7]  = '{1'b1, CNT,   1'b0, 1'b0, 8'b0001_0010};
        tbl[8]  = '{1'b0, 6'd0,  1'b0, 1'b1, 8'b0000_0000};
        tbl[9]  = '{1'b0, 6'd0,  1'b0, 1'b1, 8'b0000_0000};
        tbl[10] = '{1'b1, ENDC,  1'b0, 1'b0, 8'b0100_1010};
        tbl[11] = '{1'b1, ENDC,  1'b0, 1'b1, 8'b0100_1000};
        tbl[12] = '{1'b1, SHS,   1'b0, 1'b0, 8'b1100_0000};
        tbl[13] = '{1'b1, LOCK,  1'b0, 1'b0, 8'b0100_1110};
        tbl[14] = '{1'b1, RHB,   1'b0, 1'b0, 8'b0000_0010};
        tbl[15] = '{1'b1, RHB,   1'b1, 1'b0, 8'b0000_0011};
        tbl[16] = '{1'b1, LRHB,  1'b1, 1'b0, 8'b0000_0011};
        tbl[17] = '{1'b1, LRHB,  1'b0, 1'b0, 8'b0000_0010};

        // Legal count order: shift right, new MSB is XNOR of the two low bits.
        s = 6'b000000;
        for (int i = 0; i < 57; i++) begin
            seq[i] = s;
            s = {~(s[0] ^ s[1]), s[5:1]};
        end

        // Reset state
        do_reset();
        check("reset_state", {24'd0, dut_vec()}, 32'b0100_0010);

        // Vector table from reset
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].h, tbl[i].l, tbl[i].hm, tbl[i].ws);
            check($sformatf("tbl%0d", i), {24'd0, dut_vec()}, {24'd0, tbl[i].exp});
        end

        // Free-running lines
        do_reset();
        for (int ln = 0; ln < 2; ln++) begin
            run_line(-1, -1, 99);
            check("hsync_rise", hs_rise, 4);
            check("hsync_clks", hs_clks, 16);
            check("cburst_rise", cb_rise, 8);
            check("cburst_clks", cb_clks, 16);
            check("hblank_fall", hb_fall, 16);
            check("center_cnt", ce_cnt, 1);
            check("center_at", ce_at, 36);
            check("lreset_cnt", lr_cnt, 1);
            check("lreset_at", lr_at, 56);
            check("hblank_eol", hblank, 1);
        end

        // HMOVE early
        run_line(2, -1, 99);
        check("hm_early_set", hm_after_strobe, 1);
        check("hm_early_fall", hb_fall, 18);
        check("hm_early_clr", hm_at18, 0);

        // HMOVE late
        run_line(17, -1, 99);
        check("hm_late_fall", hb_fall, 16);
        check("hm_late_set", hm_after_strobe, 1);
        check("hm_late_hb", hblank, 1);
        check("hm_late_clr", hm_at18, 0);

        // WSYNC mid-line
        run_line(-1, 30, 99);
        check("ws_rdy_low", rdy_after_ws, 0);
        check("ws_rdy_eol", rdy_at56, 1);

        // WSYNC coinciding with end of line
        run_line(-1, 56, 99);
        check("ws_eol_low", rdy_at56, 0);
        run_line(-1, -1, 99);
        check("ws_next_eol", rdy_at56, 1);

        // Lock-up while hsync is high
        run_line(-1, -1, 6);
        check("pre_lock_hs", hsync, 1);
        step(1, LOCK, 0, 0);
        check("lock_err", lock_err, 1);
        check("lock_lreset", lfsr_reset, 1);
        check("lock_hb", hblank, 1);
        check("lock_hs", hsync, 0);
        step(0, LOCK, 0, 0);
        check("lock_err_1clk", lock_err, 0);
        check("lock_lr_1clk", lfsr_reset, 0);

        // Asynchronous reset mid-hsync with a WSYNC stall pending
        run_line(-1, 2, 6);
        check("pre_rst_hs", hsync, 1);
        check("pre_rst_rdy", rdy, 0);
        #2 reset_n = 0;
        #1;
        check("arst_hs", hsync, 0);
        check("arst_hb", hblank, 1);
        check("arst_rdy", rdy, 1);
        model_reset();
        hphi2_en = 0; hmove_strobe = 0; wsync_strobe = 0;
        @(posedge clk); @(posedge clk); #3;
        reset_n = 1;
        run_line(-1, -1, 99);
        check("post_rst_hs_rise", hs_rise, 4);
        check("post_rst_hs_clks", hs_clks, 16);
        check("post_rst_lr_at", lr_at, 56);

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] l;
            logic [2:0] pick;
            pick = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                case (pick)
                    3'd0: l = SHS;  3'd1: l = RHS;  3'd2: l = RCB;  3'd3: l = RHB;
                    3'd4: l = LRHB; 3'd5: l = CNT;  3'd6: l = ENDC; default: l = LOCK;
                endcase
            end else begin
                l = 6'($urandom_range(0, 63));
            end
            step($urandom_range(0, 1) == 1, l, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
